// File: rtl/axil_bk_pkg.sv
// Shared types and helpers for the AXI-Lite backend register file.
package axil_bk_pkg;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } rd_state_t;

    localparam int STATUS_OFS = 0;
    localparam int EVT_OFS    = 1;
    localparam int MASK_OFS   = 2;

    localparam logic [31:0] RSVD_RDATA = 32'h0;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_bk_rdpipe.sv
// Fixed-latency read pipeline: one outstanding read, down-counter to done,
// overlapping strobes are dropped and flagged on overrun.
module axil_bk_rdpipe
    import axil_bk_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        rstart,
    input  logic [31:0] rword,
    output logic        rdone,
    output logic [31:0] rdata,
    output logic        overrun
);

    localparam logic [1:0] LOAD = 2'(RD_LAT - 1);

    rd_state_t   state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] data_q, data_n;
    logic        ovr_q, ovr_n;
    logic        at_tc;

    assign at_tc = (state == R_WAIT) && (cnt == 2'd0);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state  <= R_IDLE;
            cnt    <= 2'd0;
            data_q <= 32'h0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            ovr_q  <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data_q;
        ovr_n   = 1'b0;
        case (state)
            R_IDLE: begin
                if (rstart) begin
                    state_n = R_WAIT;
                    cnt_n   = LOAD;
                    data_n  = rword;
                end
            end
            R_WAIT: begin
                if (cnt == 2'd0) begin
                    // A strobe coinciding with done starts the next read.
                    if (rstart) begin
                        cnt_n  = LOAD;
                        data_n = rword;
                    end else begin
                        state_n = R_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 2'd1;
                    ovr_n = rstart;
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

    assign rdone   = at_tc;
    assign rdata   = at_tc ? data_q : 32'h0;
    assign overrun = ovr_q;

endmodule

// File: rtl/axilite_bk_regfile.sv
// Backend register file: CTRL bank, STATUS, optional W1C EVT + IRQ_MASK.
// Optional event/irq block enabled by defining AXIL_BK_EVT_IRQ_EN.
module axilite_bk_regfile
    import axil_bk_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter int          RD_LAT   = 1,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  bk_wstart,
    input  logic [14:0]           bk_waddr,
    input  logic [31:0]           bk_wdata,
    input  logic [3:0]            bk_wstrb,
    input  logic                  bk_rstart,
    input  logic [14:0]           bk_raddr,
    output logic [31:0]           bk_rdata,
    output logic                  bk_rdone,
    output logic [NUM_REGS*32-1:0] ctrl_q,
    input  logic [31:0]           sts_in,
    input  logic [31:0]           evt_in,
    output logic                  irq,
    output logic                  rd_overrun
);

    localparam logic [12:0] IDX_STS  = 13'(NUM_REGS + STATUS_OFS);
    localparam logic [12:0] IDX_EVT  = 13'(NUM_REGS + EVT_OFS);
    localparam logic [12:0] IDX_MASK = 13'(NUM_REGS + MASK_OFS);

    logic [12:0] widx, ridx;
    logic [31:0] ctrl_r [NUM_REGS];
    logic [31:0] rd_word;
    logic        unused_addr;

    assign widx        = bk_waddr[14:2];
    assign ridx        = bk_raddr[14:2];
    assign unused_addr = &{1'b0, bk_waddr[1:0], bk_raddr[1:0]};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) ctrl_r[k] <= CTRL_RST;
        end else if (bk_wstart) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (widx == 13'(k)) ctrl_r[k] <= byte_merge(ctrl_r[k], bk_wdata, bk_wstrb);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_q[32*g +: 32] = ctrl_r[g];
    end

`ifdef AXIL_BK_EVT_IRQ_EN
    logic [31:0] evt_r, mask_r, evt_clr;

    assign evt_clr = (bk_wstart && widx == IDX_EVT) ? byte_merge(32'h0, bk_wdata, bk_wstrb) : 32'h0;

    // New events win over a same-cycle clear.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            evt_r  <= 32'h0;
            mask_r <= 32'h0;
            irq    <= 1'b0;
        end else begin
            evt_r <= (evt_r & ~evt_clr) | evt_in;
            if (bk_wstart && widx == IDX_MASK) mask_r <= byte_merge(mask_r, bk_wdata, bk_wstrb);
            irq <= |(evt_r & mask_r);
        end
    end
`else
    logic unused_evt;
    assign unused_evt = &{1'b0, evt_in};
    assign irq        = 1'b0;
`endif

    always_comb begin
        rd_word = RSVD_RDATA;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ridx == 13'(k)) rd_word = ctrl_r[k];
        end
        if (ridx == IDX_STS) rd_word = sts_in;
`ifdef AXIL_BK_EVT_IRQ_EN
        if (ridx == IDX_EVT)  rd_word = evt_r;
        if (ridx == IDX_MASK) rd_word = mask_r;
`endif
    end

    axil_bk_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .rstart      (bk_rstart),
        .rword       (rd_word),
        .rdone       (bk_rdone),
        .rdata       (bk_rdata),
        .overrun     (rd_overrun)
    );

endmodule

// File: tb/tb_axilite_bk_regfile.sv
// Directed bench: u3 (RD_LAT=3, CTRL_RST=all ones) and u1 (defaults) share stimulus.
module tb_axilite_bk_regfile;

    logic         axi_aclk = 1'b0;
    logic         axi_aresetn;
    logic         bk_wstart, bk_rstart;
    logic [14:0]  bk_waddr, bk_raddr;
    logic [31:0]  bk_wdata, sts_in, evt_in;
    logic [3:0]   bk_wstrb;

    logic [31:0]  rdata3, rdata1;
    logic         rdone3, rdone1, irq3, irq1, ovr3, ovr1;
    logic [255:0] ctrl3, ctrl1;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 axi_aclk = ~axi_aclk;

    axilite_bk_regfile #(.NUM_REGS(8), .RD_LAT(3), .CTRL_RST(32'hFFFF_FFFF)) u3 (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
        .bk_rstart(bk_rstart), .bk_raddr(bk_raddr), .bk_rdata(rdata3), .bk_rdone(rdone3),
        .ctrl_q(ctrl3), .sts_in(sts_in), .evt_in(evt_in), .irq(irq3), .rd_overrun(ovr3)
    );

    axilite_bk_regfile #(.NUM_REGS(8)) u1 (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
        .bk_rstart(bk_rstart), .bk_raddr(bk_raddr), .bk_rdata(rdata1), .bk_rdone(rdone1),
        .ctrl_q(ctrl1), .sts_in(sts_in), .evt_in(evt_in), .irq(irq1), .rd_overrun(ovr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic rd(input logic [14:0] a);
        bk_rstart = 1'b1;
        bk_raddr  = a;
        step();
        bk_rstart = 1'b0;
    endtask

    task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
        bk_wstart = 1'b1;
        bk_waddr  = a;
        bk_wdata  = d;
        bk_wstrb  = s;
        step();
        bk_wstart = 1'b0;
    endtask

    logic seen;

    initial begin
        axi_aresetn = 1'b0;
        bk_wstart = 1'b0; bk_rstart = 1'b0;
        bk_waddr = '0; bk_raddr = '0; bk_wdata = '0; bk_wstrb = '0;
        sts_in = 32'hCAFE_F00D; evt_in = '0;
        step(); step();
        chk("rst_rdone", {31'b0, rdone3}, 32'd0);
        chk("rst_rdata", rdata3, 32'h0);
        chk("rst_irq", {31'b0, irq3}, 32'd0);
        chk("rst_ovr", {31'b0, ovr3}, 32'd0);
        chk("rst_ctrl0_u3", ctrl3[31:0], 32'hFFFF_FFFF);
        chk("rst_ctrl7_u1", ctrl1[255:224], 32'h0);
        #3 axi_aresetn = 1'b1;
        step();

        // Read index 0: u1 done at T+1, u3 done at T+3
        rd(15'h0000);
        chk("lat1_rdone", {31'b0, rdone1}, 32'd1);
        chk("lat1_rdata", rdata1, 32'h0);
        chk("lat3_early", {31'b0, rdone3}, 32'd0);
        step();
        chk("lat3_t2", {31'b0, rdone3}, 32'd0);
        step();
        chk("lat3_rdone", {31'b0, rdone3}, 32'd1);
        chk("lat3_rdata", rdata3, 32'hFFFF_FFFF);
        step();
        chk("lat3_done_gone", {31'b0, rdone3}, 32'd0);
        chk("rdata_zero_idle", rdata3, 32'h0);

        // Byte-lane write into CTRL[2]
        wr(15'h0008, 32'hA5A5_1234, 4'b0101);
        chk("strb_ctrl2_u3", ctrl3[95:64], 32'hFFA5_FF34);
        chk("strb_ctrl2_u1", ctrl1[95:64], 32'h00A5_0034);
        wr(15'h0008, 32'h0000_0000, 4'b0000);
        chk("strb0_noop", ctrl3[95:64], 32'hFFA5_FF34);
        wr(15'h000B, 32'h0000_0077, 4'b0001);
        chk("addr_lsb_ignored", ctrl1[95:64], 32'h00A5_0077);
        rd(15'h0008); step(); step();
        chk("rb_ctrl2", rdata3, 32'h00A5_0077 | 32'hFF00_FF00);
        step();

        // Same-cycle write and read of CTRL[1]
        bk_wstart = 1'b1; bk_waddr = 15'h0004; bk_wdata = 32'h1234_5678; bk_wstrb = 4'hF;
        rd(15'h0004);
        bk_wstart = 1'b0;
        chk("rw_same_u1_old", rdata1, 32'h0);
        chk("rw_same_ctrlq", ctrl3[63:32], 32'h1234_5678);
        step(); step();
        chk("rw_same_u3_old", rdata3, 32'hFFFF_FFFF);
        step();
        rd(15'h0004);
        chk("rw_next_u1_new", rdata1, 32'h1234_5678);
        step(); step();
        chk("rw_next_u3_new", rdata3, 32'h1234_5678);
        step();

        // Overrun: second strobe one cycle after the first
        rd(15'h0008);
        rd(15'h0004);
        chk("ovr_pulse", {31'b0, ovr3}, 32'd1);
        chk("ovr_no_done", {31'b0, rdone3}, 32'd0);
        step();
        chk("ovr_done", {31'b0, rdone3}, 32'd1);
        chk("ovr_first_data", rdata3, 32'hFFA5_FF77);
        chk("ovr_pulse_once", {31'b0, ovr3}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | rdone3;
        end
        chk("ovr_single_done", {31'b0, seen}, 32'd0);

        // Back-to-back: strobe in the done cycle is accepted (status read)
        rd(15'h0000); step(); step();
        chk("b2b_first_done", {31'b0, rdone3}, 32'd1);
        rd(15'h0020);
        chk("b2b_no_ovr", {31'b0, ovr3}, 32'd0);
        sts_in = 32'h0BAD_BEEF;
        step(); step();
        chk("b2b_second_done", {31'b0, rdone3}, 32'd1);
        chk("b2b_status", rdata3, 32'hCAFE_F00D);
        step();

        // Reserved indices
        rd(15'h002C); step(); step();
        chk("rsvd_done", {31'b0, rdone3}, 32'd1);
        chk("rsvd_zero", rdata3, 32'h0);
        step();
        rd(15'h7FFC);
        chk("rsvd_top_u1", rdata1, 32'h0);
        step();

`ifdef AXIL_BK_EVT_IRQ_EN
        wr(15'h0028, 32'h0000_0010, 4'hF);
        evt_in = 32'h10;
        step();
        evt_in = 32'h0;
        chk("irq_t1", {31'b0, irq3}, 32'd0);
        step();
        chk("irq_t2", {31'b0, irq3}, 32'd1);
        evt_in = 32'h10;
        wr(15'h0024, 32'h0000_0010, 4'h1);
        evt_in = 32'h0;
        step();
        chk("w1c_set_wins_irq", {31'b0, irq1}, 32'd1);
        rd(15'h0024);
        chk("w1c_set_wins_evt", rdata1, 32'h10);
        step();
        wr(15'h0024, 32'h0000_0010, 4'hE);
        step();
        chk("w1c_lane_off", {31'b0, irq1}, 32'd1);
        wr(15'h0024, 32'h0000_0010, 4'hF);
        chk("w1c_irq_lag", {31'b0, irq1}, 32'd1);
        step();
        chk("w1c_irq_drop", {31'b0, irq1}, 32'd0);
        rd(15'h0028);
        chk("mask_rb", rdata1, 32'h10);
        step();
`else
        wr(15'h0028, 32'h0000_0010, 4'hF);
        evt_in = 32'h10;
        step();
        evt_in = 32'h0;
        step(); step();
        chk("noevt_irq0", {31'b0, irq1}, 32'd0);
        rd(15'h0024);
        chk("noevt_evt_rsvd", rdata1, 32'h0);
        step();
        rd(15'h0028);
        chk("noevt_mask_rsvd", rdata1, 32'h0);
        step();
`endif

        // Reset during R_WAIT: pending read discarded
        rd(15'h0004);
        #2 axi_aresetn = 1'b0;
        step();
        chk("midrst_ctrl", ctrl3[63:32], 32'hFFFF_FFFF);
        #3 axi_aresetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | rdone3 | rdone1;
        end
        chk("midrst_no_done", {31'b0, seen}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axilite_bk_regfile.md
# axilite_bk_regfile

Backend register file that terminates the posted-write / single-read backend interface of the AXI-Lite slave front end. It decodes backend word addresses into a bank of read/write control registers, a read-only status register, and an optional write-1-to-clear event register with masked interrupt. Read data returns through a fixed-latency pipeline with a single-cycle done pulse. It sits directly downstream of the AXI-Lite slave inside the user-project AA path.

## Interface
- NUM_REGS, 8: number of R/W control registers, 1..64.
- RD_LAT, 1: cycles from bk_rstart to bk_rdone, 1..4.
- CTRL_RST, 32'h0: reset value of every control register.
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- bk_wstart  in  1  one-cycle write strobe.
- bk_waddr  in  15  byte address; word index = bk_waddr[14:2]; [1:0] ignored.
- bk_wdata  in  32  write data.
- bk_wstrb  in  4  byte enables; bit i gates byte i.
- bk_rstart  in  1  one-cycle read strobe.
- bk_raddr  in  15  byte address, same decode as writes.
- bk_rdata  out  32  read data; valid only while bk_rdone=1, else 0.
- bk_rdone  out  1  one-cycle read-complete pulse.
- ctrl_q  out  NUM_REGS*32  flattened control registers; reg k at [32k+31:32k].
- sts_in  in  32  hardware status, readable at index NUM_REGS.
- evt_in  in  32  event pulses, one bit per source.
- irq  out  1  registered interrupt.
- rd_overrun  out  1  one-cycle pulse when a read is dropped.

## Operation
- Address map (word index): 0..NUM_REGS-1 CTRL RW; NUM_REGS STATUS RO; NUM_REGS+1 EVT W1C; NUM_REGS+2 IRQ_MASK RW; all others reserved.
- Write: on bk_wstart, update addressed byte lanes where bk_wstrb[i]=1; wstrb=0 is a no-op. Writes to STATUS/reserved ignored.
- EVT: bit set by evt_in[i]=1; cleared by write of 1 with lane enabled. Set and clear same cycle: set wins.
- irq <= |(EVT & IRQ_MASK), registered one cycle after EVT/MASK change.
- Read: sampled in the bk_rstart cycle (pre-write value if bk_wstart hits same word same cycle); STATUS returns sts_in as sampled; reserved returns 32'h0.
- Single outstanding read: FSM R_IDLE -> R_WAIT on bk_rstart; down-counter loaded RD_LAT-1; bk_rdone asserted when counter reaches 0 in R_WAIT, then R_IDLE. bk_rstart while R_WAIT: dropped, rd_overrun pulses, pending read unaffected.
- bk_rstart in the same cycle bk_rdone is high (back-to-back) accepted.

## Timing
- Reset values: bk_rdata=0, bk_rdone=0, irq=0, rd_overrun=0, CTRL=CTRL_RST, EVT=0, IRQ_MASK=0, FSM R_IDLE.
- Write visible on ctrl_q next cycle after bk_wstart; readback from a following-cycle read returns new value.
- bk_rdone at cycle T+RD_LAT for bk_rstart at cycle T; throughput one read per RD_LAT cycles.
- Reset asserted mid-read: pending read discarded, no bk_rdone after release.
- evt_in set to irq: 2 cycles with mask set.

## Configuration
- AXIL_BK_EVT_IRQ_EN defined: EVT and IRQ_MASK registers, irq logic present.
- Undefined: indices NUM_REGS+1/+2 treated as reserved (read 0, writes ignored), evt_in unused, irq tied 0.

## Structure
- Shared package axil_bk_pkg: read FSM state enum, index offsets (STATUS_OFS=0, EVT_OFS=1, MASK_OFS=2 relative to NUM_REGS), reserved read value, byte-merge function (old, new, strb).
- One sub-module: axil_bk_rdpipe (read FSM, latency counter, rdone/rdata registers, overrun pulse).

## Test plan
- Reset, read index 0 -> bk_rdone at T+RD_LAT, bk_rdata=CTRL_RST; irq=0.
- Write 0xA5A5_1234 strb 4'b0101 to CTRL[2] over 0xFFFF_FFFF -> readback 0xFFA5_FF34, ctrl_q slice matches next cycle.
- Write and read same word same cycle -> read returns old value; next read new value.
- RD_LAT=3: second bk_rstart at T+1 -> rd_overrun pulse, single bk_rdone at T+3 with first address's data.
- (EN) evt_in[4] pulse, mask 0x10 -> irq=1 two cycles later; write 0x10 to EVT while evt_in[4]=1 -> bit stays set; clear with evt_in idle -> irq drops.
- Reset during R_WAIT -> no bk_rdone after release; reserved index read -> 0.
